// File: rtl/ask_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ask_uart_pkg
// Description : Constants shared by the ASK UART RX and TX paths: deframer
//               state encodings and the number of data bits per character.
// Revision    : 1.0 - initial release
// ============================================================================
package ask_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/ask_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ask_uart_rx_fifo
// Description : Synchronous first-word-fall-through FIFO. The head entry is
//               visible on rd_data whenever empty is low; rd_data reads 0
//               while empty. Writes to a full FIFO are ignored, even when a
//               read happens in the same cycle.
// Ports       : clk, rst (async, active-high)
//               wr_en / wr_data  - push side
//               rd_en / rd_data  - pop side (pop ignored when empty)
//               level            - entries held, 0..DEPTH
//               full, empty      - status flags
// Revision    : 1.0 - initial release
// ============================================================================
module ask_uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int             c_aw      = $clog2(DEPTH);
    localparam logic [c_aw:0]  c_ptr_one = (c_aw + 1)'(1);

    // Pointers carry one extra MSB so full and empty can be told apart
    // when the address bits match.
    logic [c_aw:0]      r_wr_ptr;
    logic [c_aw:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic               w_do_wr;
    logic               w_do_rd;

    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign level   = r_wr_ptr - r_rd_ptr;

    assign w_do_wr = wr_en & ~full;
    assign w_do_rd = rd_en & ~empty;

    // Masked while empty so the output is a clean 0 rather than stale data.
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_ask_uart_rx_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : axis_ask_uart_rx_wrapper
// Description : ASK UART receiver with AXI-Stream master output. Slices ASK
//               amplitude samples into a line bit, synchronizes it, deframes
//               8N1 characters (LSB first) and buffers bytes in an FWFT FIFO
//               presented on an AXIS master.
// Ports       : clk, rst (async, active-high)
//               ask_rx      - ASK amplitude sample (asynchronous)
//               o_tdata     - received byte
//               o_tvalid    - FIFO not empty
//               o_tready    - downstream accept
//               o_tuser     - bad stop bit flag (only with the macro below)
//               fifo_level  - bytes held, 0..RX_SIZE
//               overrun     - sticky, byte dropped on full FIFO
//               frame_err   - 1-cycle pulse on a low stop bit
//               busy        - deframer not idle
// Config      : AXIS_ASK_UART_RX_TUSER_EN - when defined, bad-stop bytes are
//               stored with o_tuser=1 instead of being discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_ask_uart_rx_wrapper
    import ask_uart_pkg::*;
#(
    parameter int ask_rx_length = 2,
    parameter int ASK_THRESHOLD = 2,
    parameter int RX_SIZE       = 16,
    parameter int clkdiv_rx     = 100
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ask_rx_length-1:0]  ask_rx,
    output logic [7:0]                o_tdata,
    output logic                      o_tvalid,
    input  logic                      o_tready,
`ifdef AXIS_ASK_UART_RX_TUSER_EN
    output logic                      o_tuser,
`endif
    output logic [15:0]               fifo_level,
    output logic                      overrun,
    output logic                      frame_err,
    output logic                      busy
);

    // The counter is tested for zero before it is decremented, so loading
    // N-1 gives an interval of exactly N clocks.
    localparam logic [15:0] c_bit_reload  = 16'(clkdiv_rx - 1);
    localparam logic [15:0] c_half_reload = 16'((clkdiv_rx >> 1) - 1);
    localparam int          c_idx_w       = $clog2(UART_DATA_BITS);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(UART_DATA_BITS - 1);
    localparam int          c_lvl_w       = $clog2(RX_SIZE) + 1;
`ifdef AXIS_ASK_UART_RX_TUSER_EN
    localparam int          c_fifo_w      = UART_DATA_BITS + 1;
`else
    localparam int          c_fifo_w      = UART_DATA_BITS;
`endif

    // ------------------------------------------------------------------
    // Slicer and synchronizer. The compare is done on the raw sample so
    // only a single bit crosses into the clock domain.
    // ------------------------------------------------------------------
    logic w_line_bit;
    logic r_sync1;
    logic r_sync2;
    logic w_rx_s;

    assign w_line_bit = (32'(ask_rx) >= $unsigned(ASK_THRESHOLD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= w_line_bit;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // ------------------------------------------------------------------
    // Deframer FSM
    // ------------------------------------------------------------------
    uart_state_t                 r_state;
    uart_state_t                 w_state_next;
    logic [15:0]                 r_cnt;
    logic [15:0]                 w_cnt_next;
    logic [c_idx_w-1:0]          r_idx;
    logic [c_idx_w-1:0]          w_idx_next;
    logic [UART_DATA_BITS-1:0]   r_data;
    logic [UART_DATA_BITS-1:0]   w_data_next;
    logic                        w_good_stop;
    logic                        w_bad_stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_data  <= w_data_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_data_next  = r_data;
        w_good_stop  = 1'b0;
        w_bad_stop   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = ST_START;
                    w_cnt_next   = c_half_reload;
                end
            end

            ST_START: begin
                if (r_cnt == 16'd0) begin
                    if (!w_rx_s) begin
                        w_state_next = ST_DATA;
                        w_cnt_next   = c_bit_reload;
                        w_idx_next   = '0;
                    end else begin
                        // Line returned high before mid-bit: a glitch.
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end

            ST_DATA: begin
                if (r_cnt == 16'd0) begin
                    w_data_next[r_idx] = w_rx_s;
                    w_cnt_next         = c_bit_reload;
                    if (r_idx == c_last_idx) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_idx_next = r_idx + c_idx_w'(1);
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end

            ST_STOP: begin
                if (r_cnt == 16'd0) begin
                    // Returning straight to IDLE lets a line that is still
                    // low after a bad stop bit start a new frame at once.
                    w_state_next = ST_IDLE;
                    if (w_rx_s) begin
                        w_good_stop = 1'b1;
                    end else begin
                        w_bad_stop  = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO and AXIS side
    // ------------------------------------------------------------------
    logic                 w_fifo_wr;
    logic [c_fifo_w-1:0]  w_fifo_wdata;
    logic [c_fifo_w-1:0]  w_fifo_rdata;
    logic [c_lvl_w-1:0]   w_level;
    logic                 w_full;
    logic                 w_empty;
    logic                 r_overrun;
    logic                 r_frame_err;

`ifdef AXIS_ASK_UART_RX_TUSER_EN
    assign w_fifo_wr    = w_good_stop | w_bad_stop;
    assign w_fifo_wdata = {w_bad_stop, r_data};
    assign o_tuser      = w_fifo_rdata[UART_DATA_BITS];
`else
    assign w_fifo_wr    = w_good_stop;
    assign w_fifo_wdata = r_data;
`endif

    ask_uart_rx_fifo #(
        .WIDTH (c_fifo_w),
        .DEPTH (RX_SIZE)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_fifo_wr),
        .wr_data (w_fifo_wdata),
        .rd_en   (o_tready),
        .rd_data (w_fifo_rdata),
        .level   (w_level),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            // A pop in the same cycle does not free space for this write.
            if (w_fifo_wr && w_full) begin
                r_overrun <= 1'b1;
            end
            r_frame_err <= w_bad_stop;
        end
    end

    assign o_tdata    = w_fifo_rdata[UART_DATA_BITS-1:0];
    assign o_tvalid   = ~w_empty;
    assign fifo_level = 16'(w_level);
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axis_ask_uart_rx_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_ask_uart_rx_wrapper
// Description : Self-checking bench for axis_ask_uart_rx_wrapper with
//               clkdiv_rx=16. Expected bytes go into a scoreboard queue as
//               frames are sent; a monitor logs every AXIS handshake and the
//               directed sequence compares the log against the queue.
//               Honours AXIS_ASK_UART_RX_TUSER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_ask_uart_rx_wrapper;

    localparam int c_div = 16;

    logic        clk;
    logic        rst;
    logic [1:0]  ask_rx;
    logic [7:0]  o_tdata;
    logic        o_tvalid;
    logic        o_tready;
    logic [15:0] fifo_level;
    logic        overrun;
    logic        frame_err;
    logic        busy;
    logic        w_tuser_obs;

`ifdef AXIS_ASK_UART_RX_TUSER_EN
    logic        o_tuser;
    assign w_tuser_obs = o_tuser;
`else
    assign w_tuser_obs = 1'b0;
`endif

    axis_ask_uart_rx_wrapper #(
        .ask_rx_length (2),
        .ASK_THRESHOLD (2),
        .RX_SIZE       (16),
        .clkdiv_rx     (c_div)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ask_rx     (ask_rx),
        .o_tdata    (o_tdata),
        .o_tvalid   (o_tvalid),
        .o_tready   (o_tready),
`ifdef AXIS_ASK_UART_RX_TUSER_EN
        .o_tuser    (o_tuser),
`endif
        .fifo_level (fifo_level),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Monitor: logs handshakes and counts activity, on the falling edge.
    // ------------------------------------------------------------------
    logic [8:0] rx_log [64];
    int         rx_cnt      = 0;
    int         tv_cycles   = 0;
    int         fe_cycles   = 0;
    int         busy_cycles = 0;
    int         hold_err    = 0;
    logic       prev_stall  = 1'b0;
    logic [7:0] prev_data   = 8'h00;

    always @(negedge clk) begin
        if (o_tvalid && o_tready) begin
            rx_log[rx_cnt % 64] <= {w_tuser_obs, o_tdata};
            rx_cnt <= rx_cnt + 1;
        end
        if (o_tvalid)  tv_cycles   <= tv_cycles + 1;
        if (frame_err) fe_cycles   <= fe_cycles + 1;
        if (busy)      busy_cycles <= busy_cycles + 1;
        if (prev_stall && !(o_tvalid && o_tdata == prev_data)) begin
            hold_err <= hold_err + 1;
        end
        prev_stall <= o_tvalid && !o_tready && !rst;
        prev_data  <= o_tdata;
    end

    // ------------------------------------------------------------------
    // Checking and stimulus
    // ------------------------------------------------------------------
    int         n_pass  = 0;
    int         n_total = 0;
    int         rd_idx  = 0;
    logic [8:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        ask_rx = b ? 2'd3 : 2'd0;
        tick(c_div);
    endtask

    // Full 8N1 frame followed by one idle bit time.
    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
        drive_bit(1'b1);
    endtask

    task automatic compare_received(input string tag);
        logic [8:0] e;
        logic [31:0] obs;
        check({tag, "_count"}, 32'(rx_cnt - rd_idx), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = (rd_idx < rx_cnt) ? 32'(rx_log[rd_idx % 64]) : 32'hDEAD;
            check(tag, obs, 32'(e));
            rd_idx++;
        end
        rd_idx = rx_cnt;
    endtask

    task automatic wait_drained();
        for (int i = 0; i < 100 && fifo_level != 16'd0; i++) tick(1);
        tick(2);
    endtask

    initial begin
        int base_tv;
        int base_fe;
        int base_busy;

        rst      = 1'b1;
        ask_rx   = 2'd3;
        o_tready = 1'b0;
        tick(3);
        check("rst_tvalid",  32'(o_tvalid),   32'd0);
        check("rst_tdata",   32'(o_tdata),    32'd0);
        check("rst_level",   32'(fifo_level), 32'd0);
        check("rst_overrun", 32'(overrun),    32'd0);
        check("rst_ferr",    32'(frame_err),  32'd0);
        check("rst_busy",    32'(busy),       32'd0);
        rst = 1'b0;
        tick(4);

        // 1: single byte with downstream ready
        o_tready = 1'b1;
        base_tv  = tv_cycles;
        base_fe  = fe_cycles;
        exp_q.push_back({1'b0, 8'hA5});
        send_byte(8'hA5, 1'b1);
        compare_received("t1_byte");
        check("t1_tvalid_cycles", 32'(tv_cycles - base_tv), 32'd1);
        check("t1_no_ferr",       32'(fe_cycles - base_fe), 32'd0);
        check("t1_busy_after",    32'(busy),                32'd0);

        // 2: three bytes held while stalled, then drained in order
        o_tready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back({1'b0, 8'(i)});
            send_byte(8'(i), 1'b1);
        end
        check("t2_level",      32'(fifo_level), 32'd3);
        check("t2_head",       32'(o_tdata),    32'h01);
        tick(5);
        o_tready = 1'b1;
        wait_drained();
        compare_received("t2_order");
        check("t2_level_zero", 32'(fifo_level), 32'd0);
        check("t2_hold",       32'(hold_err),   32'd0);

        // 3: 17 bytes into a 16-entry FIFO
        o_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back({1'b0, 8'(8'h40 + i)});
            send_byte(8'(8'h40 + i), 1'b1);
        end
        check("t3_level_full", 32'(fifo_level), 32'd16);
        check("t3_overrun",    32'(overrun),    32'd1);
        o_tready = 1'b1;
        wait_drained();
        compare_received("t3_bytes");
        check("t3_overrun_sticky", 32'(overrun),  32'd1);
        check("t3_hold",           32'(hold_err), 32'd0);

        // 4: bad stop bit
        base_fe = fe_cycles;
`ifdef AXIS_ASK_UART_RX_TUSER_EN
        exp_q.push_back({1'b1, 8'h3C});
`endif
        send_byte(8'h3C, 1'b0);
        tick(c_div);
        check("t4_ferr_pulse", 32'(fe_cycles - base_fe), 32'd1);
        check("t4_level",      32'(fifo_level),          32'd0);
        compare_received("t4_bad_stop");
        check("t4_busy",       32'(busy),                32'd0);

        // 5: short low glitch on the idle line
        base_fe   = fe_cycles;
        base_busy = busy_cycles;
        ask_rx = 2'd0;
        tick(4);
        ask_rx = 2'd3;
        tick(3 * c_div);
        check("t5_saw_start", 32'(busy_cycles != base_busy), 32'd1);
        check("t5_busy",      32'(busy),                     32'd0);
        check("t5_no_ferr",   32'(fe_cycles - base_fe),      32'd0);
        check("t5_level",     32'(fifo_level),               32'd0);
        compare_received("t5_no_byte");

        // 6: reset in the middle of a frame, then a clean byte
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        tick(4);
        check("t6_busy_mid", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(2);
        check("t6_rst_tvalid",  32'(o_tvalid),   32'd0);
        check("t6_rst_tdata",   32'(o_tdata),    32'd0);
        check("t6_rst_level",   32'(fifo_level), 32'd0);
        check("t6_rst_overrun", 32'(overrun),    32'd0);
        check("t6_rst_ferr",    32'(frame_err),  32'd0);
        check("t6_rst_busy",    32'(busy),       32'd0);
        ask_rx = 2'd3;
        tick(1);
        rst = 1'b0;
        tick(2 * c_div);
        exp_q.push_back({1'b0, 8'h55});
        send_byte(8'h55, 1'b1);
        compare_received("t6_byte");
        check("t6_overrun", 32'(overrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
